// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver: 7 data bits LSB first, odd parity, 1 stop bit.
// Samples the synchronized line at mid-bit and reports the character with parity/stop status.
module rx_serial_7o1 #(
    parameter int unsigned M = 434,
    parameter int unsigned N = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    input  logic       recebe_dado,
    output logic [6:0] dados_ascii,
    output logic       paridade_ok,
    output logic       erro_stop,
    output logic       pronto,
    output logic       tem_dado,
    output logic [3:0] db_estado
);

    localparam int unsigned MEIO_BIT   = M / 2 - 1;
    localparam int unsigned FIM_BIT    = M - 1;
    localparam int unsigned N_AMOSTRAS = 9;
    localparam int unsigned SHIFT_W    = 9;
    localparam int unsigned AMOSTRA_W  = 4;

    typedef enum logic [2:0] {
        INICIAL      = 3'd0,
        ESPERA_START = 3'd1,
        RECEPCAO     = 3'd2,
        ARMAZENA     = 3'd3,
        FINAL        = 3'd4
    } estado_t;

    estado_t                estado;
    logic                   rx_meta;
    logic                   rx_s;
    logic [N-1:0]           cnt_bit;
    logic [AMOSTRA_W-1:0]   n_amostra;
    logic [SHIFT_W-1:0]     shift;

    // Two-flop synchronizer; idle-high reset so no false start leaves reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= dado_serial;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with its counters, shift register and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= INICIAL;
            cnt_bit     <= '0;
            n_amostra   <= '0;
            shift       <= 9'h1FF;
            dados_ascii <= '0;
            paridade_ok <= 1'b0;
            erro_stop   <= 1'b0;
            pronto      <= 1'b0;
            tem_dado    <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                INICIAL: begin
                    cnt_bit   <= '0;
                    n_amostra <= '0;
                    if (!rx_s) begin
                        estado <= ESPERA_START;
                    end
                end
                ESPERA_START: begin
                    if (cnt_bit == N'(MEIO_BIT)) begin
                        cnt_bit <= '0;
                        estado  <= rx_s ? INICIAL : RECEPCAO;
                    end else begin
                        cnt_bit <= cnt_bit + N'(1);
                    end
                end
                RECEPCAO: begin
                    if (cnt_bit == N'(FIM_BIT)) begin
                        cnt_bit   <= '0;
                        shift     <= {rx_s, shift[SHIFT_W-1:1]};
                        n_amostra <= n_amostra + AMOSTRA_W'(1);
                        if (n_amostra == AMOSTRA_W'(N_AMOSTRAS - 1)) begin
                            estado <= ARMAZENA;
                        end
                    end else begin
                        cnt_bit <= cnt_bit + N'(1);
                    end
                end
                ARMAZENA: begin
                    dados_ascii <= shift[6:0];
                    paridade_ok <= ^shift[7:0];
                    erro_stop   <= ~shift[8];
                    pronto      <= 1'b1;
                    estado      <= FINAL;
                end
                FINAL: begin
                    estado <= INICIAL;
                end
                default: begin
                    estado <= INICIAL;
                end
            endcase

            // Set lands on entry to FINAL and wins over a simultaneous acknowledge
            if (estado == ARMAZENA) begin
                tem_dado <= 1'b1;
            end else if (recebe_dado && estado != FINAL) begin
                tem_dado <= 1'b0;
            end
        end
    end

    assign db_estado = 4'(estado);

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1 with M=8: drives 7O1 frames and compares each pronto
// event against a frame-level model of the expected character, flags and timing.
module tb_rx_serial_7o1;

    localparam int unsigned M   = 8;
    localparam int unsigned N   = 4;
    localparam int          LAT = 80;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dado_serial = 1'b1;
    logic       recebe_dado = 1'b0;
    logic [6:0] dados_ascii;
    logic       paridade_ok;
    logic       erro_stop;
    logic       pronto;
    logic       tem_dado;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    rx_serial_7o1 #(.M(M), .N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .dado_serial(dado_serial),
        .recebe_dado(recebe_dado),
        .dados_ascii(dados_ascii),
        .paridade_ok(paridade_ok),
        .erro_stop  (erro_stop),
        .pronto     (pronto),
        .tem_dado   (tem_dado),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [6:0] d;
        logic       p;
        logic       e;
        logic       t;
    } ev_t;

    ev_t evq[$];
    bit  b2b_mode   = 1'b0;
    bit  seen_first = 1'b0;
    int  tem_low    = 0;

    // Record every pronto cycle with the outputs visible in it
    always @(negedge clock) begin
        ev_t ev;
        if (!b2b_mode) seen_first = 1'b0;
        if (pronto === 1'b1) begin
            ev.c = cyc; ev.d = dados_ascii; ev.p = paridade_ok;
            ev.e = erro_stop; ev.t = tem_dado;
            evq.push_back(ev);
            if (b2b_mode) seen_first = 1'b1;
        end
        if (b2b_mode && seen_first && tem_dado !== 1'b1) tem_low++;
    end

    function automatic logic [9:0] make_frame(input logic [6:0] c, input bit bad_par, input bit stop_v);
        logic par;
        par = (($countones(c) % 2) == 0);
        if (bad_par) par = ~par;
        return {stop_v, par, c, 1'b0};
    endfunction

    task automatic send_bits(input logic [9:0] b, input int nb, output int start);
        start = 0;
        for (int i = 0; i < nb; i++) begin
            @(posedge clock);
            #1;
            if (i == 0) start = cyc;
            dado_serial = b[i];
            repeat (7) @(posedge clock);
        end
    endtask

    task automatic idle(input int n);
        @(posedge clock);
        #1;
        dado_serial = 1'b1;
        repeat (n - 1) @(posedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; dado_serial = 1'b1; recebe_dado = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (dados_ascii !== 7'h00) begin errors++; $display("FAIL reset_dados got=%h exp=00", dados_ascii); end
        checks++; if (paridade_ok !== 1'b0) begin errors++; $display("FAIL reset_paridade got=%b exp=0", paridade_ok); end
        checks++; if (erro_stop !== 1'b0) begin errors++; $display("FAIL reset_erro_stop got=%b exp=0", erro_stop); end
        checks++; if (pronto !== 1'b0) begin errors++; $display("FAIL reset_pronto got=%b exp=0", pronto); end
        checks++; if (tem_dado !== 1'b0) begin errors++; $display("FAIL reset_tem_dado got=%b exp=0", tem_dado); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL reset_estado got=%0d exp=0", db_estado); end
        repeat (200) @(posedge clock);
        @(negedge clock);
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL idle_no_pronto got=%0d exp=0", evq.size()); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL idle_estado got=%0d exp=0", db_estado); end
    endtask

    task automatic test_frame_a();
        int  s;
        ev_t ev;
        evq.delete();
        send_bits(10'b1110000010, 10, s);
        idle(16);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL a_pulses got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            checks++; if (ev.c != s + LAT) begin errors++; $display("FAIL a_latency got=%0d exp=%0d", ev.c - s, LAT); end
            checks++; if (ev.d !== 7'h41) begin errors++; $display("FAIL a_dados got=%h exp=41", ev.d); end
            checks++; if (ev.p !== 1'b1) begin errors++; $display("FAIL a_paridade got=%b exp=1", ev.p); end
            checks++; if (ev.e !== 1'b0) begin errors++; $display("FAIL a_erro_stop got=%b exp=0", ev.e); end
            checks++; if (ev.t !== 1'b1) begin errors++; $display("FAIL a_tem_dado got=%b exp=1", ev.t); end
        end
        @(posedge clock); #1 recebe_dado = 1'b1;
        @(negedge clock);
        checks++; if (tem_dado !== 1'b1) begin errors++; $display("FAIL ack_before_edge got=%b exp=1", tem_dado); end
        @(posedge clock); #1 recebe_dado = 1'b0;
        @(negedge clock);
        checks++; if (tem_dado !== 1'b0) begin errors++; $display("FAIL ack_clear got=%b exp=0", tem_dado); end
    endtask

    task automatic test_flag_errors();
        int  s;
        ev_t ev;
        evq.delete();
        send_bits(make_frame(7'h41, 1'b1, 1'b1), 10, s);
        idle(16);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL par_pulses got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            checks++; if (ev.d !== 7'h41) begin errors++; $display("FAIL par_dados got=%h exp=41", ev.d); end
            checks++; if (ev.p !== 1'b0) begin errors++; $display("FAIL par_paridade got=%b exp=0", ev.p); end
            checks++; if (ev.e !== 1'b0) begin errors++; $display("FAIL par_erro_stop got=%b exp=0", ev.e); end
        end
        evq.delete();
        send_bits(make_frame(7'h5A, 1'b0, 1'b0), 10, s);
        idle(16);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL stop_pulses got=%0d exp=1", evq.size()); end
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            checks++; if (ev.d !== 7'h5A) begin errors++; $display("FAIL stop_dados got=%h exp=5a", ev.d); end
            checks++; if (ev.p !== 1'b1) begin errors++; $display("FAIL stop_paridade got=%b exp=1", ev.p); end
            checks++; if (ev.e !== 1'b1) begin errors++; $display("FAIL stop_erro_stop got=%b exp=1", ev.e); end
        end
    endtask

    task automatic test_glitch();
        int in_start = 0;
        evq.delete();
        @(posedge clock); #1 dado_serial = 1'b0;
        repeat (2) @(posedge clock);
        #1 dado_serial = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (db_estado === 4'd1) in_start++;
        end
        checks++; if (in_start != 4) begin errors++; $display("FAIL glitch_cycles got=%0d exp=4", in_start); end
        checks++; if (db_estado !== 4'd0) begin errors++; $display("FAIL glitch_estado got=%0d exp=0", db_estado); end
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL glitch_pronto got=%0d exp=0", evq.size()); end
        checks++; if (dados_ascii !== 7'h5A || erro_stop !== 1'b1) begin
            errors++; $display("FAIL glitch_hold got=%h/%b exp=5a/1", dados_ascii, erro_stop);
        end
    endtask

    task automatic test_random();
        int         s;
        ev_t        ev;
        logic [9:0] b;
        logic [6:0] c;
        bit         pe, sv, ack, exp_p, exp_e;
        for (int i = 0; i < 20; i++) begin
            c  = 7'($urandom_range(0, 127));
            pe = ($urandom_range(0, 3) == 0);
            sv = ($urandom_range(0, 3) != 0);
            b  = make_frame(c, pe, sv);
            exp_p = (($countones(b[8:1]) % 2) == 1);
            exp_e = (b[9] == 1'b0);
            evq.delete();
            send_bits(b, 10, s);
            idle(16);
            checks++; if (evq.size() != 1) begin errors++; $display("FAIL rnd%0d_pulses got=%0d exp=1", i, evq.size()); end
            if (evq.size() > 0) begin
                ev = evq.pop_front();
                checks++; if (ev.c != s + LAT) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, ev.c - s, LAT); end
                checks++; if (ev.d !== c) begin errors++; $display("FAIL rnd%0d_dados got=%h exp=%h", i, ev.d, c); end
                checks++; if (ev.p !== exp_p) begin errors++; $display("FAIL rnd%0d_paridade got=%b exp=%b", i, ev.p, exp_p); end
                checks++; if (ev.e !== exp_e) begin errors++; $display("FAIL rnd%0d_erro_stop got=%b exp=%b", i, ev.e, exp_e); end
                checks++; if (ev.t !== 1'b1) begin errors++; $display("FAIL rnd%0d_tem_dado got=%b exp=1", i, ev.t); end
            end
            ack = ($urandom_range(0, 1) == 1);
            if (ack) begin
                @(posedge clock); #1 recebe_dado = 1'b1;
                @(posedge clock); #1 recebe_dado = 1'b0;
            end
            @(negedge clock);
            checks++; if (tem_dado !== !ack) begin errors++; $display("FAIL rnd%0d_ack got=%b exp=%b", i, tem_dado, !ack); end
        end
    endtask

    task automatic test_back_to_back();
        int  s1, s2;
        ev_t ev;
        @(posedge clock); #1 recebe_dado = 1'b1;
        @(posedge clock); #1 recebe_dado = 1'b0;
        evq.delete();
        b2b_mode = 1'b1;
        send_bits(make_frame(7'h30, 1'b0, 1'b1), 10, s1);
        send_bits(make_frame(7'h7F, 1'b0, 1'b1), 10, s2);
        idle(8);
        b2b_mode = 1'b0;
        checks++; if (evq.size() != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", evq.size()); end
        if (evq.size() == 2) begin
            ev = evq.pop_front();
            checks++; if (ev.c != s1 + LAT || ev.d !== 7'h30) begin
                errors++; $display("FAIL b2b_first got=%0d/%h exp=%0d/30", ev.c - s1, ev.d, LAT);
            end
            ev = evq.pop_front();
            checks++; if (ev.c != s2 + LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", ev.c - s2, LAT); end
            checks++; if (ev.d !== 7'h7F) begin errors++; $display("FAIL b2b_dados got=%h exp=7f", ev.d); end
            checks++; if (ev.p !== 1'b1 || ev.e !== 1'b0) begin
                errors++; $display("FAIL b2b_flags got=%b/%b exp=1/0", ev.p, ev.e);
            end
        end
        checks++; if (tem_low != 0) begin errors++; $display("FAIL b2b_tem_dado_drop got=%0d exp=0", tem_low); end
    endtask

    task automatic test_reset_mid_frame();
        int s1, s2;
        evq.delete();
        send_bits(make_frame(7'h30, 1'b0, 1'b1), 10, s1);
        send_bits(make_frame(7'h7F, 1'b0, 1'b1), 5, s2);
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock);
        checks++; if (dados_ascii !== 7'h00 || paridade_ok !== 1'b0 || erro_stop !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got=%h/%b/%b exp=00/0/0", dados_ascii, paridade_ok, erro_stop);
        end
        checks++; if (tem_dado !== 1'b0 || pronto !== 1'b0 || db_estado !== 4'd0) begin
            errors++; $display("FAIL rst_mid_status got=%b/%b/%0d exp=0/0/0", tem_dado, pronto, db_estado);
        end
        @(posedge clock); #1 reset = 1'b0; dado_serial = 1'b1;
        repeat (100) @(posedge clock);
        @(negedge clock);
        checks++; if (evq.size() != 1) begin errors++; $display("FAIL rst_mid_pulses got=%0d exp=1", evq.size()); end
        checks++; if (dados_ascii !== 7'h00 || tem_dado !== 1'b0) begin
            errors++; $display("FAIL rst_mid_after got=%h/%b exp=00/0", dados_ascii, tem_dado);
        end
    endtask

    initial begin
        test_reset();
        test_frame_a();
        test_flag_errors();
        test_glitch();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_serial_7o1.md
# rx_serial_7o1

Serial receiver for the 7O1 UART link: 7 data bits LSB first, odd parity, 1 stop bit. It is the stage directly downstream of the 7O1 transmitter. It samples the serial line at mid-bit and presents the received ASCII character with parity/stop status. A one-cycle `pronto` pulse and a sticky `tem_dado` flag, cleared by the consumer, signal each new character.

## Interface
- `M`, default 434: clock cycles per bit (50 MHz / 115200 baud). Must be ≥ 4.
- `N`, default 9: width of the bit-period counter; satisfies 2^N > M.
- `clock`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces every register to its reset value.
- `dado_serial`  in  1  serial line, idles high; asynchronous to `clock`.
- `recebe_dado`  in  1  consumer acknowledge; clears `tem_dado`.
- `dados_ascii`  out  7  last received character. Reset value 0.
- `paridade_ok`  out  1  1 when the last frame had odd total parity (data + parity bit). Reset value 0.
- `erro_stop`  out  1  1 when the last frame's stop bit sampled 0. Reset value 0.
- `pronto`  out  1  one-cycle pulse when the outputs update. Reset value 0.
- `tem_dado`  out  1  sticky "unread character" flag. Reset value 0.
- `db_estado`  out  4  current FSM state code, for debug. Reset value 0.

## Operation
- Input path: 2-flop synchronizer on `dado_serial` produces `rx_s`. The FSM sees only `rx_s`. Synchronizer reset value is 1.
- Datapath:
  - N-bit bit-period counter with synchronous clear.
  - 4-bit sample counter, values 0..9.
  - 9-bit shift register, shifting right with the new sample entering at bit 8. Reset value 9'h1FF.
  - Output registers for `dados_ascii`, `paridade_ok` and `erro_stop`.
- FSM states (code):
  - `inicial` (0): counters cleared. If `rx_s`=0, go to `espera_start`.
  - `espera_start` (1): count cycles. At count M/2−1 (integer division), re-check `rx_s`:
    - `rx_s`=0: valid start bit. Go to `recepcao` with the counter cleared.
    - `rx_s`=1: false start (glitch). Return to `inicial` with no output change.
  - `recepcao` (2): count to M−1; at that cycle shift `rx_s` into the register and increment the sample counter.
    - Sample order: 7 data bits (LSB first), parity, stop.
    - After the 9th sample, go to `armazena`.
  - `armazena` (3), one cycle:
    - `dados_ascii` ← shift[6:0].
    - `paridade_ok` ← ^shift[7:0].
    - `erro_stop` ← ~shift[8].
  - `final` (4), one cycle: `pronto`=1, `tem_dado` set. Go to `inicial`.
- The line is not re-checked for idle before the next start bit. A low `rx_s` in `inicial` immediately after `final` starts a new frame, so back-to-back frames are supported.
- `tem_dado`:
  - Set in `final`.
  - Cleared on a clock edge with `recebe_dado`=1 outside `final`.
  - If both happen in the same cycle, set wins.
- Output registers hold their values until the next `armazena`.
- A bad parity or stop bit is reported only through the flags. The frame is still delivered with `pronto`.
- Unused state codes go to `inicial`.
- `reset` asserted mid-frame:
  - Abandons the frame immediately and returns all outputs to their reset values.
  - Does not produce a `pronto` pulse.

## Timing
- Synchronizer latency is 2 cycles from the pin to `rx_s`.
- Let E0 be the edge where `inicial` sees `rx_s`=0. Relative to E0:
  - Start-bit check at E0+M/2.
  - Bit k (k=0..8) sampled at E0+M/2+(k+1)·M.
  - `armazena` occupies the cycle after E0+M/2+9M.
  - `pronto` is high for exactly one cycle, after edge E0+M/2+9M+1.
  - The outputs and `tem_dado` are valid in that same cycle.
- For M=8, `pronto` is high 77 cycles after E0.
- Tolerance: each sample stays inside its bit cell for a baud mismatch up to ±(M/2−1)/(10M).

## Test plan
Use M=8, N=4. A "frame" is 10 bit-cells of 8 cycles each, driven on `dado_serial`.
- Reset then idle: hold `reset` for 3 cycles with the line high → all outputs 0, `db_estado`=0, no `pronto` for 200 cycles.
- Valid frame 'A' (0x41): bits 0,1,0,0,0,0,0,1,1,1 → one `pronto` pulse; `dados_ascii`=7'h41, `paridade_ok`=1, `erro_stop`=0, `tem_dado`=1. Pulse `recebe_dado` → `tem_dado`=0 next cycle.
- Parity error: 0x41 sent with parity bit 0 → `dados_ascii`=7'h41, `paridade_ok`=0, `pronto` pulses.
- Stop error: 'Z' (0x5A, parity 1) sent with stop bit 0 → `dados_ascii`=7'h5A, `erro_stop`=1.
- Glitch: line low for 2 cycles then high → state returns to 0 after 4 cycles in state 1, no `pronto`, outputs unchanged.
- Back-to-back 0x30 then 0x7F with no idle gap:
  - Two `pronto` pulses.
  - Second pulse with `dados_ascii`=7'h7F, `paridade_ok`=1.
  - `tem_dado` stays 1 throughout.
  - A `reset` asserted mid-second-frame → no second pulse and all outputs 0.
